// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative RV32M multiply/divide unit. One bit of the product or quotient is
//   produced per cycle (32 iterations). Division by zero and signed DIV/REM
//   overflow take a single-cycle fast path and never enter RUN.
//
// Ports
//   clk           clock, rising-edge
//   rst           asynchronous active-high reset
//   i_start       request strobe
//   i_aluControl  5-bit op code (11xxx = M extension, [2:0] = funct3)
//   i_a, i_b      rs1 / rs2 operands, latched at acceptance
//   i_kill        synchronous abort (pipeline flush), wins over i_start
//   o_busy        high while iterating (RUN)
//   o_done        one-cycle pulse, o_result valid
//   o_result      registered result, held until the next o_done
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int XLEN = 32  // only 32 is supported
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic [4:0]      i_aluControl,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic            i_kill,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [5:0]      LAST_ITER = 6'd31;
  localparam logic [XLEN-1:0] INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

  state_t state_q, state_d;

  // Latched operation context
  logic [2:0]      op_q;        // funct3 of the accepted op
  logic            neg_prod_q;  // negate product / quotient
  logic            neg_rem_q;   // negate remainder
  logic [5:0]      cnt_q;
  logic [XLEN-1:0] hi_q;        // mul: product high half, div: partial remainder
  logic [XLEN-1:0] lo_q;        // mul: multiplier / product low, div: dividend / quotient
  logic [XLEN-1:0] opb_q;       // mul: multiplicand, div: divisor
  logic [XLEN-1:0] result_q;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic [2:0]      f3;
  logic            is_div, a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            accept, div_zero, div_ovf, fast;
  logic [XLEN-1:0] fast_result;

  always_comb begin
    f3       = i_aluControl[2:0];
    is_div   = f3[2];
    // DIV/REM signed, DIVU/REMU unsigned; MUL/MULH signed, MULHSU mixed, MULHU unsigned
    a_signed = is_div ? ~f3[0] : (f3 != 3'b011);
    b_signed = is_div ? ~f3[0] : ~f3[1];
    a_neg    = a_signed & i_a[XLEN-1];
    b_neg    = b_signed & i_b[XLEN-1];
    a_mag    = a_neg ? (~i_a + 1'b1) : i_a;
    b_mag    = b_neg ? (~i_b + 1'b1) : i_b;

    accept   = i_start && (i_aluControl[4:3] == 2'b11) && !i_kill && (state_q != S_RUN);

    div_zero = is_div && (i_b == '0);
    div_ovf  = is_div && !f3[0] && (i_a == INT_MIN) && (i_b == '1);
    fast     = div_zero || div_ovf;

    // f3[1] selects REM/REMU over DIV/DIVU
    if (div_zero) fast_result = f3[1] ? i_a : '1;
    else          fast_result = f3[1] ? '0  : INT_MIN;
  end

  // ---------------------------------------------------------------------------
  // One iteration step
  // ---------------------------------------------------------------------------
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_sub;
  logic [XLEN-1:0]   hi_d, lo_d;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, final_result;

  // NOTE: every variable gets a value before any branch, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;

    // Shift-add: conditionally add the multiplicand into the high half, then
    // shift the 65-bit {carry, hi, lo} right by one.
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);

    // Restoring division: bring in the next dividend bit and subtract the
    // divisor if it fits. When it fits the difference is < 2^32, so a 32-bit
    // subtract is exact.
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, opb_q});
    div_sub   = div_shift[XLEN-1:0] - opb_q;

    if (op_q[2]) begin
      hi_d = div_ge ? div_sub : div_shift[XLEN-1:0];
      lo_d = {lo_q[XLEN-2:0], div_ge};
    end else begin
      hi_d = mul_sum[XLEN:1];
      lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
    end

    // Sign fix-up applied to the values produced by the final iteration
    prod   = {hi_d, lo_d};
    prod_s = neg_prod_q ? (~prod + 1'b1) : prod;
    quo_s  = neg_prod_q ? (~lo_d + 1'b1) : lo_d;
    rem_s  = neg_rem_q  ? (~hi_d + 1'b1) : hi_d;

    case (op_q)
      3'b000:                 final_result = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_result = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_result = quo_s;
      default:                final_result = rem_s;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register sees
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next-state
  always_comb begin
    state_d = state_q;
    if (i_kill) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (accept) state_d = fast ? S_DONE : S_RUN;
        S_RUN:   if (cnt_q == LAST_ITER) state_d = S_DONE;
        S_DONE:  state_d = accept ? (fast ? S_DONE : S_RUN) : S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    o_busy   = (state_q == S_RUN);
    o_done   = (state_q == S_DONE);
    o_result = result_q;
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= '0;
      neg_prod_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      opb_q      <= '0;
      result_q   <= '0;
    end else if (accept) begin
      op_q       <= f3;
      neg_prod_q <= a_neg ^ b_neg;
      neg_rem_q  <= a_neg;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= is_div ? a_mag : b_mag;
      opb_q      <= is_div ? b_mag : a_mag;
      if (fast) result_q <= fast_result;
    end else if (state_q == S_RUN && !i_kill) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q + 6'd1;
      if (cnt_q == LAST_ITER) result_q <= final_result;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Directed, table-driven bench for muldiv_unit. Inputs are driven on the
//   falling edge and outputs sampled on the falling edge, away from the rising
//   edge where the DUT updates.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        i_start;
  logic [4:0]  i_aluControl;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic        i_kill;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_result;

  int checks = 0;
  int errors = 0;

  localparam logic [4:0] OP_MUL    = 5'b11000;
  localparam logic [4:0] OP_MULH   = 5'b11001;
  localparam logic [4:0] OP_MULHSU = 5'b11010;
  localparam logic [4:0] OP_MULHU  = 5'b11011;
  localparam logic [4:0] OP_DIV    = 5'b11100;
  localparam logic [4:0] OP_DIVU   = 5'b11101;
  localparam logic [4:0] OP_REM    = 5'b11110;
  localparam logic [4:0] OP_REMU   = 5'b11111;

  typedef struct {
    string       name;
    logic [4:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;   // cycles from accepting cycle to the o_done cycle
    int          busy;  // cycles with o_busy high
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  muldiv_unit #(.XLEN(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_aluControl (i_aluControl),
    .i_a          (i_a),
    .i_b          (i_b),
    .i_kill       (i_kill),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_result     (o_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Issue one request, scramble the inputs right after acceptance, then wait
  // (bounded) for o_done and compare result, latency, busy cycles and pulse width.
  task automatic run_op(input vec_t v);
    int   cyc;
    int   busy_n;
    logic seen;
    @(negedge clk);
    i_aluControl = v.code;
    i_a          = v.a;
    i_b          = v.b;
    i_start      = 1'b1;
    @(posedge clk);
    #1;
    i_start      = 1'b0;
    i_a          = ~v.a;
    i_b          = '0;
    i_aluControl = 5'b00000;
    cyc    = 0;
    busy_n = 0;
    seen   = 1'b0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (o_busy) busy_n++;
      if (o_done) seen = 1'b1;
    end
    check({v.name, "_done_seen"}, 32'(seen), 32'd1);
    check({v.name, "_result"}, o_result, v.res);
    check({v.name, "_latency"}, 32'(cyc), 32'(v.lat));
    check({v.name, "_busy_cycles"}, 32'(busy_n), 32'(v.busy));
    @(negedge clk);
    check({v.name, "_done_pulse"}, 32'(o_done), 32'd0);
  endtask

  // Count o_done pulses over n falling edges
  task automatic count_done(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (o_done) cnt++;
    end
  endtask

  initial begin
    int          n_done;
    int          cyc;
    int          t1;
    int          t2;
    logic [31:0] last_res;

    vecs[0]  = '{"mul",          OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 32};
    vecs[1]  = '{"mulh",         OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 32};
    vecs[2]  = '{"mulhsu",       OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32};
    vecs[3]  = '{"mulhu",        OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 32};
    vecs[4]  = '{"mulh_neg",     OP_MULH,   32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33, 32};
    vecs[5]  = '{"div",          OP_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33, 32};
    vecs[6]  = '{"rem",          OP_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33, 32};
    vecs[7]  = '{"divu",         OP_DIVU,   32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 33, 32};
    vecs[8]  = '{"remu",         OP_REMU,   32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 33, 32};
    vecs[9]  = '{"div_negb",     OP_DIV,    32'h0000_0064, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 33, 32};
    vecs[10] = '{"rem_negb",     OP_REM,    32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002, 33, 32};
    vecs[11] = '{"divu_by0",     OP_DIVU,   32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, 1,  0};
    vecs[12] = '{"rem_by0",      OP_REM,    32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 1,  0};
    vecs[13] = '{"rem_ovf",      OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1,  0};
    vecs[14] = '{"div_ovf",      OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  0};

    // Reset state
    rst          = 1'b1;
    i_start      = 1'b0;
    i_aluControl = '0;
    i_a          = '0;
    i_b          = '0;
    i_kill       = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy",   32'(o_busy), 32'd0);
    check("reset_done",   32'(o_done), 32'd0);
    check("reset_result", o_result,    32'd0);
    rst = 1'b0;

    // Main function, one vector per op plus boundary cases
    for (int i = 0; i < NVEC; i++) run_op(vecs[i]);
    last_res = vecs[NVEC-1].res;

    // Kill mid-iteration: no done, result held, next request works
    @(negedge clk);
    i_aluControl = OP_MUL;
    i_a          = 32'd3;
    i_b          = 32'd5;
    i_start      = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    repeat (15) @(negedge clk);
    check("kill_busy_before", 32'(o_busy), 32'd1);
    i_kill = 1'b1;
    @(negedge clk);
    i_kill = 1'b0;
    check("kill_busy_after", 32'(o_busy), 32'd0);
    check("kill_done_after", 32'(o_done), 32'd0);
    check("kill_result_held", o_result, last_res);
    count_done(40, n_done);
    check("kill_no_done", 32'(n_done), 32'd0);
    run_op('{"mul_after_kill", OP_MUL, 32'd3, 32'd5, 32'h0000_000F, 33, 32});

    // Back-to-back: i_start held high, second op accepted in the DONE cycle
    @(negedge clk);
    i_aluControl = OP_MULHU;
    i_a          = 32'hFFFF_FFFF;
    i_b          = 32'h0000_0002;
    i_start      = 1'b1;
    @(posedge clk);
    #1;
    i_aluControl = OP_DIVU;
    i_a          = 32'h0000_0064;
    i_b          = 32'h0000_0007;
    cyc = 0;
    t1  = -1;
    t2  = -1;
    while (t2 < 0 && cyc < 120) begin
      @(negedge clk);
      cyc++;
      if (t1 >= 0 && cyc == t1 + 1) begin
        i_start = 1'b0;
        check("b2b_second_busy", 32'(o_busy), 32'd1);
      end
      if (o_done) begin
        if (t1 < 0) begin
          t1 = cyc;
          check("b2b_first_result", o_result, 32'h0000_0001);
        end else begin
          t2 = cyc;
          check("b2b_second_result", o_result, 32'h0000_000E);
        end
      end
    end
    i_start = 1'b0;
    check("b2b_first_latency", 32'(t1), 32'd33);
    check("b2b_spacing", 32'(t2 - t1), 32'd33);
    @(negedge clk);
    check("b2b_done_pulse", 32'(o_done), 32'd0);

    // Non-M code is ignored
    @(negedge clk);
    i_aluControl = 5'b00000;
    i_a          = 32'd9;
    i_b          = 32'd3;
    i_start      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ignore_code_busy_done", {30'd0, o_busy, o_done}, 32'd0);
    end
    // Kill wins over a valid start
    i_aluControl = OP_MUL;
    i_kill       = 1'b1;
    @(negedge clk);
    check("kill_over_start_busy_done", {30'd0, o_busy, o_done}, 32'd0);
    i_kill  = 1'b0;
    i_start = 1'b0;

    // Reset during RUN: outputs clear at once, no done afterwards
    @(negedge clk);
    i_aluControl = OP_MUL;
    i_a          = 32'd7;
    i_b          = 32'd6;
    i_start      = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_busy",   32'(o_busy), 32'd0);
    check("rst_mid_done",   32'(o_done), 32'd0);
    check("rst_mid_result", o_result,    32'd0);
    @(negedge clk);
    rst = 1'b0;
    count_done(40, n_done);
    check("rst_mid_no_done", 32'(n_done), 32'd0);
    run_op('{"mulhu_after_rst", OP_MULHU, 32'h8000_0000, 32'h0000_0004, 32'h0000_0002, 33, 32});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
